// File: rtl/reh4_approx_mult.sv
// rtl/reh4_approx_mult.sv - 4x4 unsigned approximate recursive multiplier with registered output
// REH4_EXACT_EN: when defined, the 2x2 blocks are exact and Y = a*b for every operand pair.
module reh4_approx_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  output logic [7:0] Y
);

`ifdef REH4_EXACT_EN
  localparam int SW = 4;
`else
  localparam int SW = 3;
`endif

  // 2x2 sub-multiplier; the approximate form drops the 4th bit by mapping 3*3 to 7.
  function automatic logic [SW-1:0] m2x2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] full;
    logic [SW-1:0] res;
    full = {2'b00, x} * {2'b00, y};
`ifdef REH4_EXACT_EN
    res = full;
`else
    res = (x == 2'd3 && y == 2'd3) ? 3'd7 : full[2:0];
`endif
    return res;
  endfunction

  logic [SW-1:0] pp_hh;
  logic [SW-1:0] pp_hl;
  logic [SW-1:0] pp_lh;
  logic [SW-1:0] pp_ll;
  logic [7:0]    p;

  always_comb begin
    pp_hh = m2x2(a[3:2], b[3:2]);
    pp_hl = m2x2(a[3:2], b[1:0]);
    pp_lh = m2x2(a[1:0], b[3:2]);
    pp_ll = m2x2(a[1:0], b[1:0]);
    // Partial products are summed exactly; the widest result (225 exact, 175 approx) fits in 8 bits.
    p = ({{(8-SW){1'b0}}, pp_hh} << 4)
      + (({{(8-SW){1'b0}}, pp_hl} + {{(8-SW){1'b0}}, pp_lh}) << 2)
      + {{(8-SW){1'b0}}, pp_ll};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y <= p;
      end
    end
  end

endmodule

// File: tb/tb_reh4_approx_mult.sv
// tb/tb_reh4_approx_mult.sv - self-checking bench for reh4_approx_mult (vector table + scoreboard + sweep)
module tb_reh4_approx_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic [7:0] Y;

  reh4_approx_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .Y(Y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y_apx;
    logic [7:0] y_ex;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_y;
    logic       sweep;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  sweep_match = 0;
  int  sweep_above = 0;

`ifdef REH4_EXACT_EN
  localparam int EXP_MATCH = 256;
`else
  localparam int EXP_MATCH = 207;
`endif

  // Reference: exact product minus 2 for every 3x3 sub-product, weighted by its position.
  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int prod;
    int err;
    prod = int'(x) * int'(y);
    err = 0;
`ifndef REH4_EXACT_EN
    if (x[3:2] == 2'd3 && y[3:2] == 2'd3) err += 2 * 16;
    if (x[3:2] == 2'd3 && y[1:0] == 2'd3) err += 2 * 4;
    if (x[1:0] == 2'd3 && y[3:2] == 2'd3) err += 2 * 4;
    if (x[1:0] == 2'd3 && y[1:0] == 2'd3) err += 2;
`endif
    return 8'(prod - err);
  endfunction

  task automatic expect_eq(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Called #1 after each rising edge: pops the scoreboard when a result is due.
  task automatic check_out();
    sb_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      expect_eq($sformatf("out_valid a=%0d b=%0d", e.a, e.b), int'(out_valid), 1);
      expect_eq($sformatf("Y a=%0d b=%0d", e.a, e.b), int'(Y), int'(e.exp_y));
      if (e.sweep) begin
        if (Y == 8'(int'(e.a) * int'(e.b))) sweep_match++;
        else if (int'(Y) > int'(e.a) * int'(e.b)) sweep_above++;
      end
    end else begin
      expect_eq("out_valid idle", int'(out_valid), 0);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] e, input logic sw);
    sb_t s;
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    if (v) begin
      s.a = x; s.b = y; s.exp_y = e; s.sweep = sw;
      sb.push_back(s);
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd5,  4'd6,  8'd30,  8'd30};
    vecs[1] = '{4'd1,  4'd13, 8'd13,  8'd13};
    vecs[2] = '{4'd0,  4'd15, 8'd0,   8'd0};
    vecs[3] = '{4'd3,  4'd3,  8'd7,   8'd9};
    vecs[4] = '{4'd12, 4'd12, 8'd112, 8'd144};
    vecs[5] = '{4'd13, 4'd1,  8'd13,  8'd13};
    vecs[6] = '{4'd15, 4'd3,  8'd35,  8'd45};
    vecs[7] = '{4'd15, 4'd15, 8'd175, 8'd225};

    rst = 1'b1;
    in_valid = 1'b0;
    a = 4'd0;
    b = 4'd0;
    #1;
    expect_eq("reset Y", int'(Y), 0);
    expect_eq("reset out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
`ifdef REH4_EXACT_EN
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].y_ex, 1'b0);
`else
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].y_apx, 1'b0);
`endif
    end

    // Hold after 15*15: out_valid drops, Y keeps the last product.
    drive(1'b0, 4'd2, 4'd2, 8'd0, 1'b0);
`ifdef REH4_EXACT_EN
    expect_eq("hold Y", int'(Y), 225);
`else
    expect_eq("hold Y", int'(Y), 175);
`endif
    drive(1'b0, 4'd7, 4'd7, 8'd0, 1'b0);
    expect_eq("hold Y second cycle", int'(Y), int'(model(4'd15, 4'd15)));

    // Asynchronous reset mid-stream with in_valid held high.
    drive(1'b1, 4'd7, 4'd2, 8'd14, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("async rst Y", int'(Y), 0);
    expect_eq("async rst out_valid", int'(out_valid), 0);
    sb.delete();
    @(posedge clk);
    #1;
    expect_eq("rst held Y", int'(Y), 0);
    expect_eq("rst held out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_eq("post rst idle Y", int'(Y), 0);
    expect_eq("post rst idle out_valid", int'(out_valid), 0);
    drive(1'b1, 4'd9, 4'd9, model(4'd9, 4'd9), 1'b0);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 4'(i >> 4), 4'(i & 15), model(4'(i >> 4), 4'(i & 15)), 1'b1);
    end
    drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
    expect_eq("sweep exact matches", sweep_match, EXP_MATCH);
    expect_eq("sweep results above a*b", sweep_above, 0);
    expect_eq("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
